// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the CPU front end.
// Owns the program counter and keeps at most one instruction-memory request
// outstanding. The returned instruction is held for decode behind a
// valid/ready handshake. Redirects from execute replace the fetch address,
// and any response to a request issued on the wrong path is dropped.

module fetch_ctrl #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  INIT  = '0,
    parameter int                STEP  = 1,
    parameter int                IW    = 16
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [IW-1:0]    imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             ins_valid,
    output logic [IW-1:0]    ins_data,
    output logic [WIDTH-1:0] ins_pc,
    input  logic             ins_ready,
    output logic [WIDTH-1:0] pc_q
);

    // REQ: asking memory, WAIT: good response pending, HOLD: instruction
    // buffered for decode, DRAIN: wrong-path response pending, HALTED: parked.
    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_fetchPc;
    logic [WIDTH-1:0] r_insPc;
    logic [IW-1:0]    r_insData;
    logic             r_insValid;

    logic [WIDTH-1:0] w_pcInc;
    logic             w_xfer;

    // Sequential increment wraps naturally at 2^WIDTH.
    assign w_pcInc   = r_pc + WIDTH'(STEP);
    assign w_xfer    = r_insValid && ins_ready;

    // Every output comes straight from registered state.
    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_pc;
    assign pc_q      = r_pc;
    assign ins_valid = r_insValid;
    assign ins_data  = r_insData;
    assign ins_pc    = r_insPc;

    // Fetch FSM: moves the PC, tracks the single outstanding request and
    // fills or empties the decode buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_REQ;
            r_pc       <= INIT;
            r_fetchPc  <= '0;
            r_insPc    <= '0;
            r_insData  <= '0;
            r_insValid <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_gnt) begin
                        r_fetchPc <= r_pc;
                        if (redirect) begin
                            r_pc    <= redirect_pc;
                            r_state <= S_DRAIN;
                        end else begin
                            r_pc    <= w_pcInc;
                            r_state <= S_WAIT;
                        end
                    end else begin
                        if (redirect) begin
                            r_pc <= redirect_pc;
                        end
                        if (halt) begin
                            r_state <= S_HALTED;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                        if (imem_rvalid) begin
                            r_state <= halt ? S_HALTED : S_REQ;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (imem_rvalid) begin
                        r_insData  <= imem_rdata;
                        r_insPc    <= r_fetchPc;
                        r_insValid <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc       <= redirect_pc;
                        r_insValid <= 1'b0;
                        r_state    <= halt ? S_HALTED : S_REQ;
                    end else if (w_xfer) begin
                        r_insValid <= 1'b0;
                        r_state    <= halt ? S_HALTED : S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end
                    if (imem_rvalid) begin
                        r_state <= halt ? S_HALTED : S_REQ;
                    end
                end
                S_HALTED: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end
                    if (!halt) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state    <= S_REQ;
                    r_insValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by a randomized run
// against a transaction-level model of the fetch front end.

module tb_fetch_ctrl;

    localparam int         W    = 8;
    localparam int         IWD  = 16;
    localparam logic [7:0] INIT = 8'h10;

    logic           clk = 1'b0;
    logic           resetn;
    logic           imem_req;
    logic [W-1:0]   imem_addr;
    logic           imem_gnt;
    logic           imem_rvalid;
    logic [IWD-1:0] imem_rdata;
    logic           redirect;
    logic [W-1:0]   redirect_pc;
    logic           halt;
    logic           ins_valid;
    logic [IWD-1:0] ins_data;
    logic [W-1:0]   ins_pc;
    logic           ins_ready;
    logic [W-1:0]   pc_q;

    int nChecks = 0;
    int nPass   = 0;

    fetch_ctrl #(.WIDTH(W), .INIT(INIT), .STEP(1), .IW(IWD)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .pc_q        (pc_q)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Transaction-level model: a request is outstanding or not, its answer
    // is either wanted or stale, the decode buffer is full or empty, and the
    // front end is either parked or free to ask.
    logic [W-1:0]   mPc;
    logic [W-1:0]   mFetchPc;
    logic [W-1:0]   mInsPc;
    logic [IWD-1:0] mInsData;
    bit             mOutstanding;
    bit             mStale;
    bit             mBufFull;
    bit             mParked;

    function automatic bit mReq();
        return !mOutstanding && !mBufFull && !mParked;
    endfunction

    task automatic modelReset();
        mPc = INIT; mFetchPc = '0; mInsPc = '0; mInsData = '0;
        mOutstanding = 0; mStale = 0; mBufFull = 0; mParked = 0;
    endtask

    task automatic modelStep();
        if (mReq()) begin
            if (imem_gnt) begin
                mOutstanding = 1;
                mFetchPc     = mPc;
                mStale       = redirect;
                mPc          = redirect ? redirect_pc : W'(mPc + 1);
            end else begin
                if (redirect) mPc = redirect_pc;
                if (halt) mParked = 1;
            end
        end else if (mOutstanding) begin
            if (redirect) mPc = redirect_pc;
            if (imem_rvalid) begin
                mOutstanding = 0;
                if (mStale || redirect) begin
                    mParked = halt;
                end else begin
                    mBufFull = 1;
                    mInsData = imem_rdata;
                    mInsPc   = mFetchPc;
                end
                mStale = 0;
            end else if (redirect) begin
                mStale = 1;
            end
        end else if (mBufFull) begin
            if (redirect) mPc = redirect_pc;
            if (redirect || ins_ready) begin
                mBufFull = 0;
                mParked  = halt;
            end
        end else begin
            if (redirect) mPc = redirect_pc;
            if (!halt) mParked = 0;
        end
    endtask

    // Advance one clock; inputs are already set and are sampled at the edge.
    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; redirect = 0;
        redirect_pc = '0; halt = 0; ins_ready = 0;
    endtask

    task automatic test_reset();
        clearInputs();
        resetn = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        nChecks++; if (imem_req !== 1'b1) $display("[TB] FAIL reset_req got %b want 1", imem_req); else nPass++;
        nChecks++; if (imem_addr !== 8'h10) $display("[TB] FAIL reset_addr got %h want 10", imem_addr); else nPass++;
        nChecks++; if (pc_q !== 8'h10) $display("[TB] FAIL reset_pc got %h want 10", pc_q); else nPass++;
        nChecks++; if (ins_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", ins_valid); else nPass++;
        nChecks++; if (ins_data !== 16'h0) $display("[TB] FAIL reset_data got %h want 0", ins_data); else nPass++;
        nChecks++; if (ins_pc !== 8'h0) $display("[TB] FAIL reset_inspc got %h want 0", ins_pc); else nPass++;
    endtask

    task automatic test_basic_fetch();
        imem_gnt = 1; step(); imem_gnt = 0;
        nChecks++; if (imem_req !== 1'b0) $display("[TB] FAIL fetch_wait_req got %b want 0", imem_req); else nPass++;
        nChecks++; if (pc_q !== 8'h11) $display("[TB] FAIL fetch_pc_inc got %h want 11", pc_q); else nPass++;
        imem_rvalid = 1; imem_rdata = 16'hABCD; step(); imem_rvalid = 0;
        nChecks++; if (ins_valid !== 1'b1) $display("[TB] FAIL fetch_valid got %b want 1", ins_valid); else nPass++;
        nChecks++; if (ins_data !== 16'hABCD) $display("[TB] FAIL fetch_data got %h want abcd", ins_data); else nPass++;
        nChecks++; if (ins_pc !== 8'h10) $display("[TB] FAIL fetch_inspc got %h want 10", ins_pc); else nPass++;
        ins_ready = 1; step(); ins_ready = 0;
        nChecks++; if (imem_req !== 1'b1) $display("[TB] FAIL fetch_next_req got %b want 1", imem_req); else nPass++;
        nChecks++; if (imem_addr !== 8'h11) $display("[TB] FAIL fetch_next_addr got %h want 11", imem_addr); else nPass++;
        nChecks++; if (ins_valid !== 1'b0) $display("[TB] FAIL fetch_drained got %b want 0", ins_valid); else nPass++;
    endtask

    task automatic test_hold_stall();
        imem_gnt = 1; step(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 16'h1234; step(); imem_rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            nChecks++; if (ins_valid !== 1'b1 || ins_data !== 16'h1234 || ins_pc !== 8'h11 || imem_req !== 1'b0)
                $display("[TB] FAIL hold_stable cyc %0d got v=%b d=%h pc=%h req=%b want v=1 d=1234 pc=11 req=0",
                         i, ins_valid, ins_data, ins_pc, imem_req);
            else nPass++;
        end
        ins_ready = 1; step(); ins_ready = 0;
        nChecks++; if (imem_req !== 1'b1 || imem_addr !== 8'h12)
            $display("[TB] FAIL hold_release got req=%b addr=%h want req=1 addr=12", imem_req, imem_addr);
        else nPass++;
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1; step(); imem_gnt = 0;
        redirect = 1; redirect_pc = 8'h40; step(); redirect = 0;
        nChecks++; if (imem_req !== 1'b0 || pc_q !== 8'h40)
            $display("[TB] FAIL redir_wait_drain got req=%b pc=%h want req=0 pc=40", imem_req, pc_q);
        else nPass++;
        step();
        imem_rvalid = 1; imem_rdata = 16'hDEAD; step(); imem_rvalid = 0;
        nChecks++; if (ins_valid !== 1'b0) $display("[TB] FAIL redir_wait_discard got %b want 0", ins_valid); else nPass++;
        nChecks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40)
            $display("[TB] FAIL redir_wait_next got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr);
        else nPass++;
    endtask

    task automatic test_redirect_req_gnt();
        imem_gnt = 1; redirect = 1; redirect_pc = 8'h60; step(); imem_gnt = 0; redirect = 0;
        nChecks++; if (imem_req !== 1'b0 || pc_q !== 8'h60)
            $display("[TB] FAIL redir_gnt_drain got req=%b pc=%h want req=0 pc=60", imem_req, pc_q);
        else nPass++;
        imem_rvalid = 1; imem_rdata = 16'hBEEF; step(); imem_rvalid = 0;
        nChecks++; if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h60)
            $display("[TB] FAIL redir_gnt_next got v=%b req=%b addr=%h want v=0 req=1 addr=60", ins_valid, imem_req, imem_addr);
        else nPass++;
    endtask

    task automatic test_wrap();
        redirect = 1; redirect_pc = 8'hFF; step(); redirect = 0;
        nChecks++; if (imem_req !== 1'b1 || imem_addr !== 8'hFF)
            $display("[TB] FAIL wrap_redirect got req=%b addr=%h want req=1 addr=ff", imem_req, imem_addr);
        else nPass++;
        imem_gnt = 1; step(); imem_gnt = 0;
        nChecks++; if (pc_q !== 8'h00) $display("[TB] FAIL wrap_pc got %h want 00", pc_q); else nPass++;
        imem_rvalid = 1; imem_rdata = 16'h5A5A; step(); imem_rvalid = 0;
        nChecks++; if (ins_pc !== 8'hFF) $display("[TB] FAIL wrap_inspc got %h want ff", ins_pc); else nPass++;
        ins_ready = 1; step(); ins_ready = 0;
        nChecks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
            $display("[TB] FAIL wrap_next got req=%b addr=%h want req=1 addr=00", imem_req, imem_addr);
        else nPass++;
    endtask

    task automatic test_halt();
        imem_gnt = 1; step(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 16'h7777; step(); imem_rvalid = 0;
        halt = 1; step();
        nChecks++; if (ins_valid !== 1'b1) $display("[TB] FAIL halt_hold_valid got %b want 1", ins_valid); else nPass++;
        ins_ready = 1; step(); ins_ready = 0;
        repeat (3) step();
        nChecks++; if (imem_req !== 1'b0 || ins_valid !== 1'b0)
            $display("[TB] FAIL halt_parked got req=%b v=%b want req=0 v=0", imem_req, ins_valid);
        else nPass++;
        redirect = 1; redirect_pc = 8'h80; step(); redirect = 0;
        nChecks++; if (pc_q !== 8'h80 || imem_req !== 1'b0)
            $display("[TB] FAIL halt_redirect got pc=%h req=%b want pc=80 req=0", pc_q, imem_req);
        else nPass++;
        halt = 0; step();
        nChecks++; if (imem_req !== 1'b1 || imem_addr !== 8'h80)
            $display("[TB] FAIL halt_release got req=%b addr=%h want req=1 addr=80", imem_req, imem_addr);
        else nPass++;
    endtask

    task automatic test_async_reset();
        imem_gnt = 1; step(); imem_gnt = 0;
        #2;
        resetn = 0;
        modelReset();
        #1;
        nChecks++; if (ins_valid !== 1'b0 || pc_q !== INIT || imem_req !== 1'b1)
            $display("[TB] FAIL async_reset got v=%b pc=%h req=%b want v=0 pc=10 req=1", ins_valid, pc_q, imem_req);
        else nPass++;
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        imem_rvalid = 1; imem_rdata = 16'hC0DE; step(); imem_rvalid = 0;
        nChecks++; if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== INIT)
            $display("[TB] FAIL stray_rvalid got v=%b req=%b addr=%h want v=0 req=1 addr=10", ins_valid, imem_req, imem_addr);
        else nPass++;
    endtask

    task automatic test_random();
        bit       memPending = 0;
        int       memDelay   = 0;
        bit       granted;
        int       errs = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_gnt    = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = W'($urandom);
            halt        = ($urandom_range(0, 11) == 0);
            ins_ready   = ($urandom_range(0, 2) != 0);
            imem_rdata  = IWD'($urandom);
            imem_rvalid = 0;
            if (memPending) begin
                memDelay--;
                if (memDelay == 0) begin
                    imem_rvalid = 1;
                    memPending  = 0;
                end
            end else if (!mBufFull && !mOutstanding && $urandom_range(0, 7) == 0) begin
                imem_rvalid = 1;
            end
            granted = mReq() && imem_gnt;
            step();
            if (granted) begin
                memPending = 1;
                memDelay   = $urandom_range(1, 3);
            end
            nChecks++;
            if (imem_req !== mReq() || imem_addr !== mPc || pc_q !== mPc || ins_valid !== mBufFull ||
                ins_data !== mInsData || ins_pc !== mInsPc) begin
                if (errs < 10)
                    $display("[TB] FAIL random cyc %0d got req=%b addr=%h pc=%h v=%b d=%h ipc=%h want req=%b pc=%h v=%b d=%h ipc=%h",
                             cyc, imem_req, imem_addr, pc_q, ins_valid, ins_data, ins_pc,
                             mReq(), mPc, mBufFull, mInsData, mInsPc);
                errs++;
            end else begin
                nPass++;
            end
        end
        clearInputs();
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_req_gnt();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
